// File: rtl/mips_alu_pkg.sv
// Shared definitions for the MIPS ALU sharing controller.
// Holds the ALU op-code and funct encodings, the controller state encoding and
// the struct used to latch a request's ALU control fields.
package mips_alu_pkg;

  // ALU op-codes seen by the ALU control unit.
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  // R-type funct field values.
  localparam logic [5:0] FUNCT_SLL = 6'h00;
  localparam logic [5:0] FUNCT_SRL = 6'h02;
  localparam logic [5:0] FUNCT_SRA = 6'h03;
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_XOR = 6'h26;
  localparam logic [5:0] FUNCT_NOR = 6'h27;

  // Controller states.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // ALU control fields captured from the winning requester.
  typedef struct packed {
    logic [1:0] op_code;
    logic [5:0] funct;
    logic       is_signed;
  } alu_ctrl_t;

endpackage

// File: rtl/alu_share_ctrl_mips_if.sv
// Bus bundle for alu_share_ctrl_mips.
// Carries both request channels, the shared ALU control/operand/result wires
// and both response channels.
//   slave  : modport used by the controller.
//   master : modport used by the requesters and the ALU model around it.
interface alu_share_ctrl_mips_if #(
  parameter int unsigned DATA_W = 32
);

  // Request channel 0 (execute path)
  logic              i_req0_valid;
  logic              o_req0_ready;
  logic [1:0]        i_req0_op_code;
  logic [5:0]        i_req0_funct;
  logic              i_req0_is_signed;
  logic [DATA_W-1:0] i_req0_a;
  logic [DATA_W-1:0] i_req0_b;

  // Request channel 1 (branch / address-calc path)
  logic              i_req1_valid;
  logic              o_req1_ready;
  logic [1:0]        i_req1_op_code;
  logic [5:0]        i_req1_funct;
  logic              i_req1_is_signed;
  logic [DATA_W-1:0] i_req1_a;
  logic [DATA_W-1:0] i_req1_b;

  // Shared ALU
  logic [1:0]        o_alu_op_code;
  logic [5:0]        o_alu_funct;
  logic              o_alu_is_signed;
  logic [DATA_W-1:0] o_alu_a;
  logic [DATA_W-1:0] o_alu_b;
  logic [DATA_W-1:0] i_alu_result;

  // Responses
  logic              o_rsp0_valid;
  logic              i_rsp0_ready;
  logic              o_rsp1_valid;
  logic              i_rsp1_ready;
  logic [DATA_W-1:0] o_rsp_data;
  logic              o_busy;

  modport slave (
    input  i_req0_valid, i_req0_op_code, i_req0_funct, i_req0_is_signed, i_req0_a, i_req0_b,
    output o_req0_ready,
    input  i_req1_valid, i_req1_op_code, i_req1_funct, i_req1_is_signed, i_req1_a, i_req1_b,
    output o_req1_ready,
    output o_alu_op_code, o_alu_funct, o_alu_is_signed, o_alu_a, o_alu_b,
    input  i_alu_result,
    output o_rsp0_valid, o_rsp1_valid, o_rsp_data, o_busy,
    input  i_rsp0_ready, i_rsp1_ready
  );

  modport master (
    output i_req0_valid, i_req0_op_code, i_req0_funct, i_req0_is_signed, i_req0_a, i_req0_b,
    input  o_req0_ready,
    output i_req1_valid, i_req1_op_code, i_req1_funct, i_req1_is_signed, i_req1_a, i_req1_b,
    input  o_req1_ready,
    input  o_alu_op_code, o_alu_funct, o_alu_is_signed, o_alu_a, o_alu_b,
    output i_alu_result,
    input  o_rsp0_valid, o_rsp1_valid, o_rsp_data, o_busy,
    output i_rsp0_ready, i_rsp1_ready
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin picker (combinational).
//   req_i        : request vector, bit N = requester N.
//   last_grant_i : requester granted most recently (register kept by parent).
//   gnt_o        : one-hot grant, all zero when nothing requests.
//   gnt_id_o     : index of the granted requester (0 when nothing requests).
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] gnt_o,
  output logic       gnt_id_o
);

  always_comb begin
    gnt_o    = 2'b00;
    gnt_id_o = 1'b0;
    if (req_i == 2'b11) begin
      // Contention: the requester that did not win last time goes first.
      gnt_id_o = ~last_grant_i;
      gnt_o    = last_grant_i ? 2'b01 : 2'b10;
    end else if (req_i[0]) begin
      gnt_o    = 2'b01;
    end else if (req_i[1]) begin
      gnt_o    = 2'b10;
      gnt_id_o = 1'b1;
    end
  end

endmodule

// File: rtl/alu_share_ctrl_mips.sv
// Shares one ALU (control unit + datapath) between two requesters.
// A round-robin winner's op-code/funct/signedness/operands are latched, driven
// onto the ALU for EXEC_CYCLES cycles, the result is captured and returned on
// the winner's response channel with a valid/ready handshake.
//   i_clk   : clock, rising edge.
//   i_rst   : synchronous active-high reset; drops any in-flight op.
//   bus_io  : request, ALU and response signals (slave side).
module alu_share_ctrl_mips
  import mips_alu_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned EXEC_CYCLES = 1   // 1..15
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  alu_share_ctrl_mips_if.slave bus_io
);

  localparam logic [3:0] CntInit = 4'(EXEC_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              grant_id_q, grant_id_d;
  logic [3:0]        cnt_q, cnt_d;
  alu_ctrl_t         ctrl_q, ctrl_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  logic [1:0] arb_req;
  logic [1:0] arb_gnt;
  logic       arb_id;
  logic       idle;
  logic       accept;
  logic       rsp_ready_sel;

  assign arb_req = {bus_io.i_req1_valid, bus_io.i_req0_valid};

  rr_arb2 u_arb (
    .req_i        (arb_req),
    .last_grant_i (last_grant_q),
    .gnt_o        (arb_gnt),
    .gnt_id_o     (arb_id)
  );

  assign idle          = (state_q == ST_IDLE);
  assign accept        = idle && (arb_gnt != 2'b00) && !i_rst;
  assign rsp_ready_sel = grant_id_q ? bus_io.i_rsp1_ready : bus_io.i_rsp0_ready;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    cnt_d        = cnt_q;
    ctrl_d       = ctrl_q;
    a_d          = a_q;
    b_d          = b_q;
    rsp_data_d   = rsp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (arb_id) begin
            ctrl_d = '{op_code: bus_io.i_req1_op_code, funct: bus_io.i_req1_funct,
                       is_signed: bus_io.i_req1_is_signed};
            a_d    = bus_io.i_req1_a;
            b_d    = bus_io.i_req1_b;
          end else begin
            ctrl_d = '{op_code: bus_io.i_req0_op_code, funct: bus_io.i_req0_funct,
                       is_signed: bus_io.i_req0_is_signed};
            a_d    = bus_io.i_req0_a;
            b_d    = bus_io.i_req0_b;
          end
          grant_id_d   = arb_id;
          last_grant_d = arb_id;
          cnt_d        = CntInit;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_q == 4'd0) begin
          rsp_data_d = bus_io.i_alu_result;
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready_sel) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;  // req0 wins the first contention
      grant_id_q   <= 1'b0;
      cnt_q        <= 4'd0;
      ctrl_q       <= '0;
      a_q          <= '0;
      b_q          <= '0;
      rsp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      cnt_q        <= cnt_d;
      ctrl_q       <= ctrl_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  // Handshake outputs are forced low while reset is asserted, whatever the state.
  assign bus_io.o_req0_ready    = accept && arb_gnt[0];
  assign bus_io.o_req1_ready    = accept && arb_gnt[1];
  assign bus_io.o_rsp0_valid    = !i_rst && (state_q == ST_RESP) && !grant_id_q;
  assign bus_io.o_rsp1_valid    = !i_rst && (state_q == ST_RESP) && grant_id_q;
  assign bus_io.o_busy          = !i_rst && !idle;
  assign bus_io.o_rsp_data      = rsp_data_q;
  assign bus_io.o_alu_op_code   = ctrl_q.op_code;
  assign bus_io.o_alu_funct     = ctrl_q.funct;
  assign bus_io.o_alu_is_signed = ctrl_q.is_signed;
  assign bus_io.o_alu_a         = a_q;
  assign bus_io.o_alu_b         = b_q;

endmodule

// File: tb/tb_alu_share_ctrl_mips.sv
module tb_alu_share_ctrl_mips;
  import mips_alu_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned E1 = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic corrupt3;
  always #5 clk = ~clk;

  alu_share_ctrl_mips_if #(.DATA_W(DW)) if1 ();
  alu_share_ctrl_mips_if #(.DATA_W(DW)) if3 ();

  alu_share_ctrl_mips #(.DATA_W(DW), .EXEC_CYCLES(E1)) u_dut1 (
    .i_clk  (clk),
    .i_rst  (rst),
    .bus_io (if1)
  );

  alu_share_ctrl_mips #(.DATA_W(DW), .EXEC_CYCLES(3)) u_dut3 (
    .i_clk  (clk),
    .i_rst  (rst),
    .bus_io (if3)
  );

  // Behavioural ALU: stands in for the shared ALU and also yields expected results.
  function automatic logic [31:0] alu_fn(input logic [1:0] op, input logic [5:0] f,
                                         input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'b01: return a - b;
      2'b10: begin
        case (f)
          6'h00:   return b << a[4:0];
          6'h02:   return b >> a[4:0];
          6'h03:   return 32'($signed(b) >>> a[4:0]);
          6'h20:   return a + b;
          6'h22:   return a - b;
          6'h24:   return a & b;
          6'h25:   return a | b;
          6'h26:   return a ^ b;
          6'h27:   return ~(a | b);
          default: return 32'h0;
        endcase
      end
      default: return a + b;
    endcase
  endfunction

  always_comb begin
    if1.i_alu_result = alu_fn(if1.o_alu_op_code, if1.o_alu_funct, if1.o_alu_a, if1.o_alu_b);
  end

  always_comb begin
    if3.i_alu_result = alu_fn(if3.o_alu_op_code, if3.o_alu_funct, if3.o_alu_a, if3.o_alu_b)
                       ^ (corrupt3 ? 32'hDEAD_BEEF : 32'h0);
  end

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle1();
    if1.i_req0_valid = 0; if1.i_req0_op_code = 0; if1.i_req0_funct = 0;
    if1.i_req0_is_signed = 0; if1.i_req0_a = 0; if1.i_req0_b = 0;
    if1.i_req1_valid = 0; if1.i_req1_op_code = 0; if1.i_req1_funct = 0;
    if1.i_req1_is_signed = 0; if1.i_req1_a = 0; if1.i_req1_b = 0;
    if1.i_rsp0_ready = 1; if1.i_rsp1_ready = 1;
  endtask

  task automatic idle3();
    if3.i_req0_valid = 0; if3.i_req0_op_code = 0; if3.i_req0_funct = 0;
    if3.i_req0_is_signed = 0; if3.i_req0_a = 0; if3.i_req0_b = 0;
    if3.i_req1_valid = 0; if3.i_req1_op_code = 0; if3.i_req1_funct = 0;
    if3.i_req1_is_signed = 0; if3.i_req1_a = 0; if3.i_req1_b = 0;
    if3.i_rsp0_ready = 1; if3.i_rsp1_ready = 1;
  endtask

  task automatic drive1(input int who, input logic v, input logic [1:0] op, input logic [5:0] f,
                        input logic s, input logic [31:0] a, input logic [31:0] b);
    if (who == 0) begin
      if1.i_req0_valid = v; if1.i_req0_op_code = op; if1.i_req0_funct = f;
      if1.i_req0_is_signed = s; if1.i_req0_a = a; if1.i_req0_b = b;
    end else begin
      if1.i_req1_valid = v; if1.i_req1_op_code = op; if1.i_req1_funct = f;
      if1.i_req1_is_signed = s; if1.i_req1_a = a; if1.i_req1_b = b;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  typedef struct {
    int          who;
    logic [1:0]  op;
    logic [5:0]  f;
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[10];

  // Random-run model state
  logic        pend[2];
  logic [1:0]  r_op[2];
  logic [5:0]  r_f[2];
  logic        r_s[2];
  logic [31:0] r_a[2];
  logic [31:0] r_b[2];
  logic [5:0]  flist[10];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gseq[$];
    int gcyc[$];
    logic inflight;
    int age, cur_who, model_last, win;
    logic [31:0] cur_exp, cur_a, cur_b;
    logic [1:0] cur_op;
    logic [5:0] cur_f;
    logic cur_s, e0, e1, rv;

    corrupt3 = 1'b0;
    idle1();
    idle3();

    tbl[0] = '{0, 2'b10, 6'h20, 1'b0, 32'd5,         32'd7,          32'd12};
    tbl[1] = '{1, 2'b01, 6'h00, 1'b0, 32'd9,         32'd4,          32'd5};
    tbl[2] = '{0, 2'b11, 6'h3F, 1'b1, 32'd3,         32'd4,          32'd7};
    tbl[3] = '{1, 2'b10, 6'h22, 1'b1, 32'd10,        32'd3,          32'd7};
    tbl[4] = '{0, 2'b10, 6'h24, 1'b0, 32'h0000_F0F0, 32'h0000_FF00,  32'h0000_F000};
    tbl[5] = '{1, 2'b10, 6'h27, 1'b0, 32'd0,         32'd0,          32'hFFFF_FFFF};
    tbl[6] = '{0, 2'b10, 6'h00, 1'b0, 32'd4,         32'd1,          32'd16};
    tbl[7] = '{1, 2'b10, 6'h03, 1'b1, 32'd4,         32'h8000_0000,  32'hF800_0000};
    tbl[8] = '{0, 2'b00, 6'h3F, 1'b0, 32'hFFFF_FFFF, 32'd1,          32'd0};
    tbl[9] = '{1, 2'b10, 6'h3F, 1'b0, 32'd1,         32'd2,          32'd0};

    flist[0] = FUNCT_SLL; flist[1] = FUNCT_SRL; flist[2] = FUNCT_SRA; flist[3] = FUNCT_ADD;
    flist[4] = FUNCT_SUB; flist[5] = FUNCT_AND; flist[6] = FUNCT_OR;  flist[7] = FUNCT_XOR;
    flist[8] = FUNCT_NOR; flist[9] = 6'h3F;

    // ---- reset state: valids high during reset must not produce readys ----
    if1.i_req0_valid = 1; if1.i_req1_valid = 1;
    @(negedge clk);
    chk1("rst_ready0", if1.o_req0_ready, 1'b0);
    chk1("rst_ready1", if1.o_req1_ready, 1'b0);
    chk1("rst_busy", if1.o_busy, 1'b0);
    chk1("rst_rsp0_valid", if1.o_rsp0_valid, 1'b0);
    chk1("rst_rsp1_valid", if1.o_rsp1_valid, 1'b0);
    @(posedge clk); #1 rst = 1'b0; idle1();
    @(negedge clk);
    chk("rst_alu_a", if1.o_alu_a, 32'h0);
    chk("rst_alu_b", if1.o_alu_b, 32'h0);
    chk("rst_alu_op", 32'(if1.o_alu_op_code), 32'h0);
    chk("rst_alu_funct", 32'(if1.o_alu_funct), 32'h0);
    chk("rst_rsp_data", if1.o_rsp_data, 32'h0);
    chk1("rst_idle_busy", if1.o_busy, 1'b0);

    // ---- table-driven single requests (EXEC_CYCLES=1) ----
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      drive1(tbl[i].who, 1'b1, tbl[i].op, tbl[i].f, tbl[i].s, tbl[i].a, tbl[i].b);
      @(negedge clk);
      chk1("tbl_ready_winner", tbl[i].who == 0 ? if1.o_req0_ready : if1.o_req1_ready, 1'b1);
      chk1("tbl_ready_other", tbl[i].who == 0 ? if1.o_req1_ready : if1.o_req0_ready, 1'b0);
      @(posedge clk); #1;
      idle1();
      @(negedge clk);
      chk("tbl_alu_op", 32'(if1.o_alu_op_code), 32'(tbl[i].op));
      chk("tbl_alu_funct", 32'(if1.o_alu_funct), 32'(tbl[i].f));
      chk1("tbl_alu_signed", if1.o_alu_is_signed, tbl[i].s);
      chk("tbl_alu_a", if1.o_alu_a, tbl[i].a);
      chk("tbl_alu_b", if1.o_alu_b, tbl[i].b);
      chk1("tbl_exec_busy", if1.o_busy, 1'b1);
      chk1("tbl_exec_no_rsp", if1.o_rsp0_valid | if1.o_rsp1_valid, 1'b0);
      @(negedge clk);
      chk1("tbl_rsp_valid", tbl[i].who == 0 ? if1.o_rsp0_valid : if1.o_rsp1_valid, 1'b1);
      chk1("tbl_rsp_other", tbl[i].who == 0 ? if1.o_rsp1_valid : if1.o_rsp0_valid, 1'b0);
      chk("tbl_rsp_data", if1.o_rsp_data, tbl[i].exp);
    end

    // ---- contention after reset: grants 0,1,0,1 spaced 3 cycles ----
    do_reset();
    drive1(0, 1'b1, 2'b10, 6'h20, 1'b0, 32'd1, 32'd2);
    drive1(1, 1'b1, 2'b01, 6'h00, 1'b0, 32'd9, 32'd4);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (if1.o_req0_ready) begin gseq.push_back(0); gcyc.push_back(c); end
      if (if1.o_req1_ready) begin gseq.push_back(1); gcyc.push_back(c); end
      if (if1.o_rsp1_valid) begin
        chk("cont_rsp1_data", if1.o_rsp_data, 32'd5);
        chk1("cont_rsp0_quiet", if1.o_rsp0_valid, 1'b0);
      end
      if (if1.o_rsp0_valid) chk("cont_rsp0_data", if1.o_rsp_data, 32'd3);
    end
    chk("cont_grant_count", 32'(gseq.size()), 32'd4);
    foreach (gseq[i]) begin
      chk("cont_grant_id", 32'(gseq[i]), 32'(i % 2));
      chk("cont_grant_cycle", 32'(gcyc[i]), 32'(3 * i));
    end
    @(posedge clk); #1 idle1();
    repeat (3) @(posedge clk);

    // ---- response backpressure on rsp0 ----
    #1;
    if1.i_rsp0_ready = 1'b0;
    drive1(0, 1'b1, 2'b10, 6'h20, 1'b0, 32'd100, 32'd23);
    @(negedge clk);
    chk1("bp_accept0", if1.o_req0_ready, 1'b1);
    @(posedge clk); #1;
    drive1(0, 1'b0, 2'b00, 6'h00, 1'b0, 32'd0, 32'd0);
    drive1(1, 1'b1, 2'b10, 6'h25, 1'b0, 32'h0000_00F0, 32'h0000_000F);
    @(negedge clk);
    chk1("bp_exec_ready1", if1.o_req1_ready, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk1("bp_rsp0_held", if1.o_rsp0_valid, 1'b1);
      chk("bp_data_stable", if1.o_rsp_data, 32'd123);
      chk1("bp_ready1_low", if1.o_req1_ready, 1'b0);
      chk1("bp_busy", if1.o_busy, 1'b1);
    end
    @(posedge clk); #1 if1.i_rsp0_ready = 1'b1;
    @(negedge clk);
    chk1("bp_hs_valid", if1.o_rsp0_valid, 1'b1);
    chk1("bp_hs_ready1_low", if1.o_req1_ready, 1'b0);
    @(negedge clk);
    chk1("bp_accept1_after", if1.o_req1_ready, 1'b1);
    @(posedge clk); #1 idle1();
    @(negedge clk);
    @(negedge clk);
    chk1("bp_rsp1_valid", if1.o_rsp1_valid, 1'b1);
    chk("bp_rsp1_data", if1.o_rsp_data, 32'h0000_00FF);

    // ---- EXEC_CYCLES=3: ALU output disturbed at T+1/T+2 is not captured ----
    @(posedge clk); #1;
    if3.i_req0_valid = 1; if3.i_req0_op_code = 2'b10; if3.i_req0_funct = 6'h26;
    if3.i_req0_a = 32'h0000_1234; if3.i_req0_b = 32'h0000_FF00;
    @(negedge clk);
    chk1("x3_accept", if3.o_req0_ready, 1'b1);
    @(posedge clk); #1 idle3(); corrupt3 = 1'b1;
    @(negedge clk);
    chk1("x3_t1_no_rsp", if3.o_rsp0_valid, 1'b0);
    chk1("x3_t1_busy", if3.o_busy, 1'b1);
    @(negedge clk);
    chk1("x3_t2_no_rsp", if3.o_rsp0_valid, 1'b0);
    @(posedge clk); #1 corrupt3 = 1'b0;
    @(negedge clk);
    chk1("x3_t3_no_rsp", if3.o_rsp0_valid, 1'b0);
    @(negedge clk);
    chk1("x3_t4_rsp", if3.o_rsp0_valid, 1'b1);
    chk("x3_t4_data", if3.o_rsp_data, 32'h0000_ED34);

    // ---- reset mid-EXEC drops the op; req0 then wins contention ----
    @(posedge clk); #1;
    if3.i_req0_valid = 1; if3.i_req0_op_code = 2'b00; if3.i_req0_a = 32'd1; if3.i_req0_b = 32'd1;
    @(negedge clk);
    chk1("rx_accept", if3.o_req0_ready, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    if3.i_req0_valid = 1; if3.i_req0_op_code = 2'b10; if3.i_req0_funct = 6'h24;
    if3.i_req0_a = 32'h0000_00FF; if3.i_req0_b = 32'h0000_000F;
    if3.i_req1_valid = 1; if3.i_req1_op_code = 2'b00; if3.i_req1_a = 32'd7; if3.i_req1_b = 32'd7;
    @(negedge clk);
    chk1("rx_rst_busy", if3.o_busy, 1'b0);
    chk1("rx_rst_ready0", if3.o_req0_ready, 1'b0);
    chk1("rx_rst_ready1", if3.o_req1_ready, 1'b0);
    chk1("rx_rst_rsp0", if3.o_rsp0_valid, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk1("rx_idle", if3.o_busy, 1'b0);
    chk1("rx_req0_wins", if3.o_req0_ready, 1'b1);
    chk1("rx_req1_loses", if3.o_req1_ready, 1'b0);
    chk1("rx_no_stale_rsp", if3.o_rsp0_valid, 1'b0);
    @(posedge clk); #1 idle3();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1("rx_wait_no_rsp", if3.o_rsp0_valid | if3.o_rsp1_valid, 1'b0);
    end
    @(negedge clk);
    chk1("rx_new_rsp", if3.o_rsp0_valid, 1'b1);
    chk("rx_new_data", if3.o_rsp_data, 32'h0000_000F);

    // ---- randomized traffic against a transaction-level model (EXEC_CYCLES=1) ----
    do_reset();
    idle1();
    pend[0] = 0; pend[1] = 0;
    inflight = 0; age = 0; cur_who = 0; model_last = 1;
    cur_exp = 0; cur_a = 0; cur_b = 0; cur_op = 0; cur_f = 0; cur_s = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(posedge clk); #1;
      for (int n = 0; n < 2; n++) begin
        if (!pend[n] && $urandom_range(0, 2) == 0) begin
          pend[n] = 1;
          r_op[n] = 2'($urandom_range(0, 3));
          r_f[n]  = flist[$urandom_range(0, 9)];
          r_s[n]  = 1'($urandom_range(0, 1));
          r_a[n]  = $urandom;
          r_b[n]  = $urandom;
        end
        drive1(n, pend[n], r_op[n], r_f[n], r_s[n], r_a[n], r_b[n]);
      end
      if1.i_rsp0_ready = ($urandom_range(0, 3) != 0);
      if1.i_rsp1_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (inflight) age++;
      win = -1;
      if (!inflight) begin
        if (pend[0] && pend[1]) win = 1 - model_last;
        else if (pend[0])       win = 0;
        else if (pend[1])       win = 1;
      end
      chk1("rnd_ready0", if1.o_req0_ready, win == 0);
      chk1("rnd_ready1", if1.o_req1_ready, win == 1);
      rv = inflight && (age >= int'(E1) + 1);
      e0 = rv && (cur_who == 0);
      e1 = rv && (cur_who == 1);
      chk1("rnd_rsp0_valid", if1.o_rsp0_valid, e0);
      chk1("rnd_rsp1_valid", if1.o_rsp1_valid, e1);
      chk1("rnd_busy", if1.o_busy, inflight);
      if (inflight && age == 1) begin
        chk("rnd_alu_a", if1.o_alu_a, cur_a);
        chk("rnd_alu_b", if1.o_alu_b, cur_b);
        chk("rnd_alu_ctrl", 32'({cur_op, cur_f, cur_s}),
            32'({if1.o_alu_op_code, if1.o_alu_funct, if1.o_alu_is_signed}));
      end
      if (rv) begin
        chk("rnd_rsp_data", if1.o_rsp_data, cur_exp);
        if ((cur_who == 0 && if1.i_rsp0_ready) || (cur_who == 1 && if1.i_rsp1_ready))
          inflight = 0;
      end
      if (win >= 0) begin
        inflight   = 1;
        age        = 0;
        cur_who    = win;
        model_last = win;
        cur_op     = r_op[win];
        cur_f      = r_f[win];
        cur_s      = r_s[win];
        cur_a      = r_a[win];
        cur_b      = r_b[win];
        cur_exp    = alu_fn(r_op[win], r_f[win], r_a[win], r_b[win]);
        pend[win]  = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
